// File: rtl/sdf_pkg.sv
// +----------------------------------------------------------------------------+
// | sdf_pkg: shared constants and arithmetic helpers for the SDF FFT stage.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package sdf_pkg;

    localparam int MODE_BF2I  = 1;
    localparam int MODE_BF2II = 2;
    localparam int ARITH_W    = 32;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    // Clamp a wide two's complement value into a w-bit signed range.
    function automatic logic signed [ARITH_W-1:0] sat_clip(input logic signed [ARITH_W-1:0] v,
                                                           input int w);
        logic signed [ARITH_W-1:0] hi;
        logic signed [ARITH_W-1:0] lo;
        hi = (ARITH_W'(1) << (w - 1)) - ARITH_W'(1);
        lo = ~hi;
        if (v > hi)      return hi;
        else if (v < lo) return lo;
        return v;
    endfunction

    function automatic logic signed [ARITH_W-1:0] sat_add(input logic signed [ARITH_W-1:0] a,
                                                          input logic signed [ARITH_W-1:0] b,
                                                          input int w);
        return sat_clip(a + b, w);
    endfunction

    function automatic logic signed [ARITH_W-1:0] sat_sub(input logic signed [ARITH_W-1:0] a,
                                                          input logic signed [ARITH_W-1:0] b,
                                                          input int w);
        return sat_clip(a - b, w);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sdf_delay_line.sv
// +----------------------------------------------------------------------------+
// | sdf_delay_line: enabled shift register holding the SDF feedback samples.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module sdf_delay_line
    import sdf_pkg::*;
#(
    parameter int DATA_WIDTH = 13,
    parameter int DEPTH      = 32
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DEPTH-1:0][DATA_WIDTH-1:0] shift_q;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] shift_d;

    always_comb begin
        shift_d    = shift_q;
        shift_d[0] = din;
        for (int k = 1; k < DEPTH; k++) begin
            shift_d[k] = shift_q[k-1];
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            shift_q <= '0;
        end else if (en) begin
            shift_q <= shift_d;
        end
    end

    assign dout = shift_q[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/sdf_stage.sv
// +----------------------------------------------------------------------------+
// | sdf_stage: radix-2^2 single-path delay-feedback FFT stage (BF2I / BF2II).  |
// | Define SDF_STAGE_SAT_EN to saturate butterfly results instead of wrapping. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module sdf_stage
    import sdf_pkg::*;
#(
    parameter int DATA_WIDTH   = 13,
    parameter int ADD_G        = 1,
    parameter int SHIFT_STAGES = 32,
    parameter int MODE         = 1
) (
    input  logic                          clock,
    input  logic                          resetn,
    input  logic                          in_valid,
    input  logic                          frame_start,
    input  logic [DATA_WIDTH-ADD_G-1:0]   prvs_r,
    input  logic [DATA_WIDTH-ADD_G-1:0]   prvs_i,
    output logic [DATA_WIDTH-1:0]         tonext_r,
    output logic [DATA_WIDTH-1:0]         tonext_i,
    output logic                          out_valid,
    output logic                          out_sync
);

    localparam int IN_W = DATA_WIDTH - ADD_G;
    localparam int SBIT = clog2(SHIFT_STAGES);
    localparam int CW   = SBIT + 1 + ((MODE == MODE_BF2II) ? 1 : 0);

    logic [DATA_WIDTH-1:0] x_r, x_i;
    logic [DATA_WIDTH-1:0] b_r, b_i;
    logic [DATA_WIDTH-1:0] fromreg_r, fromreg_i;
    logic [DATA_WIDTH-1:0] dl_in_r, dl_in_i;
    logic [DATA_WIDTH-1:0] out_r, out_i;
    logic [CW-1:0]         idx;
    logic                  s_bit, t_bit, rot;

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] tonext_r_q, tonext_r_d;
    logic [DATA_WIDTH-1:0] tonext_i_q, tonext_i_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_sync_q, out_sync_d;

    function automatic logic signed [ARITH_W-1:0] wide(input logic [DATA_WIDTH-1:0] v);
        return ARITH_W'(signed'(v));
    endfunction

    function automatic logic [DATA_WIDTH-1:0] add_op(input logic [DATA_WIDTH-1:0] a,
                                                     input logic [DATA_WIDTH-1:0] b);
`ifdef SDF_STAGE_SAT_EN
        return DATA_WIDTH'(sat_add(wide(a), wide(b), DATA_WIDTH));
`else
        return a + b;
`endif
    endfunction

    function automatic logic [DATA_WIDTH-1:0] sub_op(input logic [DATA_WIDTH-1:0] a,
                                                     input logic [DATA_WIDTH-1:0] b);
`ifdef SDF_STAGE_SAT_EN
        return DATA_WIDTH'(sat_sub(wide(a), wide(b), DATA_WIDTH));
`else
        return a - b;
`endif
    endfunction

    function automatic logic [DATA_WIDTH-1:0] neg_op(input logic [DATA_WIDTH-1:0] a);
`ifdef SDF_STAGE_SAT_EN
        return DATA_WIDTH'(sat_sub('0, wide(a), DATA_WIDTH));
`else
        return -a;
`endif
    endfunction

    generate
        if (ADD_G == 1) begin : g_sext
            assign x_r = {prvs_r[IN_W-1], prvs_r};
            assign x_i = {prvs_i[IN_W-1], prvs_i};
        end else begin : g_nosext
            assign x_r = prvs_r;
            assign x_i = prvs_i;
        end
    endgenerate

    // A frame-start sample is index 0 regardless of where the counter was.
    always_comb begin
        idx   = frame_start ? '0 : cnt_q;
        s_bit = idx[SBIT];
        t_bit = idx[CW-1];
        rot   = (MODE == MODE_BF2II) && s_bit && t_bit;

        b_r = rot ? x_i         : x_r;
        b_i = rot ? neg_op(x_r) : x_i;

        if (s_bit) begin
            dl_in_r = sub_op(fromreg_r, b_r);
            dl_in_i = sub_op(fromreg_i, b_i);
            out_r   = add_op(fromreg_r, b_r);
            out_i   = add_op(fromreg_i, b_i);
        end else begin
            dl_in_r = b_r;
            dl_in_i = b_i;
            out_r   = fromreg_r;
            out_i   = fromreg_i;
        end
    end

    always_comb begin
        cnt_d       = cnt_q;
        tonext_r_d  = tonext_r_q;
        tonext_i_d  = tonext_i_q;
        out_valid_d = in_valid;
        out_sync_d  = 1'b0;
        if (in_valid) begin
            cnt_d      = frame_start ? CW'(1) : cnt_q + CW'(1);
            tonext_r_d = out_r;
            tonext_i_d = out_i;
            // Index SHIFT_STAGES already implies t=0 in BF2II mode.
            out_sync_d = (idx == CW'(SHIFT_STAGES));
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt_q       <= '0;
            tonext_r_q  <= '0;
            tonext_i_q  <= '0;
            out_valid_q <= 1'b0;
            out_sync_q  <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            tonext_r_q  <= tonext_r_d;
            tonext_i_q  <= tonext_i_d;
            out_valid_q <= out_valid_d;
            out_sync_q  <= out_sync_d;
        end
    end

    sdf_delay_line #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(SHIFT_STAGES)) u_dl_r (
        .clock  (clock),
        .resetn (resetn),
        .en     (in_valid),
        .din    (dl_in_r),
        .dout   (fromreg_r)
    );

    sdf_delay_line #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(SHIFT_STAGES)) u_dl_i (
        .clock  (clock),
        .resetn (resetn),
        .en     (in_valid),
        .din    (dl_in_i),
        .dout   (fromreg_i)
    );

    assign tonext_r  = tonext_r_q;
    assign tonext_i  = tonext_i_q;
    assign out_valid = out_valid_q;
    assign out_sync  = out_sync_q;

endmodule

`default_nettype wire

// File: tb/tb_sdf_stage.sv
// +----------------------------------------------------------------------------+
// | tb_sdf_stage: scoreboard bench for three sdf_stage configurations.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_sdf_stage;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       in_valid = 1'b0;
    logic       frame_start = 1'b0;
    logic [11:0] pr = '0, pi = '0;
    logic [7:0]  pr2 = '0, pi2 = '0;
    logic [12:0] r0, i0, r1, i1;
    logic [7:0]  r2, i2;
    logic        ov0, ov1, ov2, sy0, sy1, sy2;

    always #5 clock = ~clock;

    // Instance 0: BF2I depth 4; instance 1: BF2II depth 2; instance 2: narrow, no growth.
    sdf_stage #(.DATA_WIDTH(13), .ADD_G(1), .SHIFT_STAGES(4), .MODE(1)) u_dut0 (
        .clock(clock), .resetn(resetn), .in_valid(in_valid), .frame_start(frame_start),
        .prvs_r(pr), .prvs_i(pi), .tonext_r(r0), .tonext_i(i0),
        .out_valid(ov0), .out_sync(sy0));

    sdf_stage #(.DATA_WIDTH(13), .ADD_G(1), .SHIFT_STAGES(2), .MODE(2)) u_dut1 (
        .clock(clock), .resetn(resetn), .in_valid(in_valid), .frame_start(frame_start),
        .prvs_r(pr), .prvs_i(pi), .tonext_r(r1), .tonext_i(i1),
        .out_valid(ov1), .out_sync(sy1));

    sdf_stage #(.DATA_WIDTH(8), .ADD_G(0), .SHIFT_STAGES(4), .MODE(1)) u_dut2 (
        .clock(clock), .resetn(resetn), .in_valid(in_valid), .frame_start(frame_start),
        .prvs_r(pr2), .prvs_i(pi2), .tonext_r(r2), .tonext_i(i2),
        .out_valid(ov2), .out_sync(sy2));

    typedef struct {
        int r;
        int i;
        bit sy;
    } smp_t;

    smp_t sb0[$], sb1[$], sb2[$];
    smp_t lg0[$], lg1[$], lg2[$];

    int  n_tests = 0;
    int  n_fail  = 0;
    int  ssv[3]  = '{4, 2, 4};
    int  modev[3] = '{1, 2, 1};
    int  dwv[3]  = '{13, 13, 8};
    int  cnt[3];
    int  ptr[3];
    int  dlr[3][8];
    int  dli[3][8];
    int  last_r[3];
    int  last_i[3];
    bit  iv_d;
    bit  mon_en = 1'b0;

    function automatic int fix(input int v, input int dw);
        int hi, m, r;
        hi = (1 << (dw - 1)) - 1;
        m  = 1 << dw;
`ifdef SDF_STAGE_SAT_EN
        if (v > hi) return hi;
        if (v < -hi - 1) return -hi - 1;
        r = v + 0 * m;
        return r;
`else
        r = v % m;
        if (r < 0) r += m;
        if (r > hi) r -= m;
        return r;
`endif
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            cnt[k] = 0;
            ptr[k] = 0;
            last_r[k] = 0;
            last_i[k] = 0;
            for (int j = 0; j < 8; j++) begin
                dlr[k][j] = 0;
                dli[k][j] = 0;
            end
        end
        sb0.delete();
        sb1.delete();
        sb2.delete();
    endtask

    // Reference: index decides butterfly half (s) and quarter (t); delay is a FIFO of depth ss.
    task automatic model_step(input int k, input bit fs, input int xr_in, input int xi_in);
        int ss, dw, idx, s, t, xr, xi, fr, fi;
        smp_t e;
        ss  = ssv[k];
        dw  = dwv[k];
        idx = fs ? 0 : cnt[k];
        cnt[k] = fs ? 1 : (cnt[k] + 1) % ((modev[k] == 2) ? 4 * ss : 2 * ss);
        s  = (idx / ss) % 2;
        t  = (idx / (2 * ss)) % 2;
        xr = xr_in;
        xi = xi_in;
        if (modev[k] == 2 && s == 1 && t == 1) begin
            xr = xi_in;
            xi = fix(-xr_in, dw);
        end
        fr = dlr[k][ptr[k]];
        fi = dli[k][ptr[k]];
        if (s == 1) begin
            e.r = fix(fr + xr, dw);
            e.i = fix(fi + xi, dw);
            dlr[k][ptr[k]] = fix(fr - xr, dw);
            dli[k][ptr[k]] = fix(fi - xi, dw);
        end else begin
            e.r = fr;
            e.i = fi;
            dlr[k][ptr[k]] = xr;
            dli[k][ptr[k]] = xi;
        end
        ptr[k] = (ptr[k] + 1) % ss;
        e.sy = (idx == ss);
        case (k)
            0: sb0.push_back(e);
            1: sb1.push_back(e);
            default: sb2.push_back(e);
        endcase
    endtask

    task automatic mon(input int k, input bit ov, input int ar, input int ai, input bit asy);
        smp_t e, a;
        bit have;
        chk($sformatf("out_valid%0d", k), ov, iv_d);
        if (ov) begin
            have = 1'b0;
            case (k)
                0: if (sb0.size() > 0) begin e = sb0.pop_front(); have = 1'b1; end
                1: if (sb1.size() > 0) begin e = sb1.pop_front(); have = 1'b1; end
                default: if (sb2.size() > 0) begin e = sb2.pop_front(); have = 1'b1; end
            endcase
            if (!have) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_out%0d: got r=%0d with nothing expected", k, ar);
            end else begin
                chk($sformatf("tonext_r%0d", k), ar, e.r);
                chk($sformatf("tonext_i%0d", k), ai, e.i);
                chk($sformatf("out_sync%0d", k), asy, e.sy);
            end
            a.r = ar;
            a.i = ai;
            a.sy = asy;
            case (k)
                0: lg0.push_back(a);
                1: lg1.push_back(a);
                default: lg2.push_back(a);
            endcase
            last_r[k] = ar;
            last_i[k] = ai;
        end else begin
            chk($sformatf("hold_r%0d", k), ar, last_r[k]);
            chk($sformatf("hold_i%0d", k), ai, last_i[k]);
            chk($sformatf("idle_sync%0d", k), asy, 0);
        end
    endtask

    always @(posedge clock or negedge resetn) begin
        if (!resetn) iv_d <= 1'b0;
        else         iv_d <= in_valid;
    end

    always @(negedge clock) begin
        if (resetn && mon_en) begin
            mon(0, ov0, int'($signed(r0)), int'($signed(i0)), sy0);
            mon(1, ov1, int'($signed(r1)), int'($signed(i1)), sy1);
            mon(2, ov2, int'($signed(r2)), int'($signed(i2)), sy2);
        end
    end

    task automatic drive(input bit v, input bit fs, input int a, input int b,
                         input int c, input int d);
        @(posedge clock);
        #1;
        in_valid    = v;
        frame_start = fs;
        pr  = 12'(a);
        pi  = 12'(b);
        pr2 = 8'(c);
        pi2 = 8'(d);
        if (v) begin
            model_step(0, fs, a, b);
            model_step(1, fs, a, b);
            model_step(2, fs, c, d);
        end
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_r0"}, int'(r0), 0);
        chk({nm, "_i0"}, int'(i0), 0);
        chk({nm, "_v0"}, int'(ov0), 0);
        chk({nm, "_s0"}, int'(sy0), 0);
        chk({nm, "_r1"}, int'(r1), 0);
        chk({nm, "_v1"}, int'(ov1), 0);
        chk({nm, "_r2"}, int'(r2), 0);
        chk({nm, "_v2"}, int'(ov2), 0);
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1;
        resetn      = 1'b0;
        in_valid    = 1'b0;
        frame_start = 1'b0;
        model_reset();
        @(negedge clock);
        check_zero("midreset");
        @(posedge clock);
        #1;
        resetn = 1'b1;
    endtask

    task automatic clear_logs();
        lg0.delete();
        lg1.delete();
        lg2.delete();
    endtask

    task automatic run_bf2i(input bit gap, input string nm);
        int er[12] = '{0, 0, 0, 0, 6, 8, 10, 12, -4, -4, -4, -4};
        clear_logs();
        for (int j = 0; j < 12; j++) begin
            drive(1'b1, (j == 0 || j == 8), (j < 8) ? j + 1 : 0, 0, 0, 0);
            if (gap) drive(1'b0, 1'b0, 0, 0, 0, 0);
        end
        drive(1'b0, 1'b0, 0, 0, 0, 0);
        drive(1'b0, 1'b0, 0, 0, 0, 0);
        chk({nm, "_len"}, lg0.size(), 12);
        if (lg0.size() == 12) begin
            for (int j = 0; j < 12; j++) begin
                chk($sformatf("%s_r[%0d]", nm, j), lg0[j].r, er[j]);
                chk($sformatf("%s_sync[%0d]", nm, j), lg0[j].sy, (j == 4) ? 1 : 0);
            end
        end
    endtask

    initial begin
        int ovf_exp;
        int fr_exp[8] = '{0, 0, 0, 0, 1, 2, 3, 12};
`ifdef SDF_STAGE_SAT_EN
        ovf_exp = 127;
`else
        ovf_exp = -56;
`endif
        model_reset();
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_zero("reset");
        @(posedge clock);
        #1;
        resetn = 1'b1;
        mon_en = 1'b1;

        run_bf2i(1'b0, "bf2i");

        for (int j = 0; j < 5; j++) begin
            drive(1'b1, 1'b0, j * 37 - 50, j * 11, j * 9 - 20, 3);
        end
        do_reset();
        run_bf2i(1'b1, "bf2i_gap");

        // BF2II rotation at index 6 and 8-bit overflow at index 4, in one frame.
        do_reset();
        clear_logs();
        for (int j = 0; j < 8; j++) begin
            drive(1'b1, (j == 0), (j == 6) ? 3 : 0, (j == 6) ? 5 : 0,
                  (j == 0 || j == 4) ? 100 : 0, 0);
        end
        drive(1'b0, 1'b0, 0, 0, 0, 0);
        drive(1'b0, 1'b0, 0, 0, 0, 0);
        chk("bf2ii_len", lg1.size(), 8);
        chk("ovf_len", lg2.size(), 8);
        if (lg1.size() == 8) begin
            chk("bf2ii_rot_r", lg1[6].r, 5);
            chk("bf2ii_rot_i", lg1[6].i, -3);
            for (int j = 0; j < 8; j++) begin
                chk($sformatf("bf2ii_sync[%0d]", j), lg1[j].sy, (j == 2) ? 1 : 0);
            end
        end
        if (lg2.size() == 8) begin
            chk("ovf_sum", lg2[4].r, ovf_exp);
        end

        // frame_start at index 3 realigns the counter.
        do_reset();
        clear_logs();
        for (int j = 0; j < 8; j++) begin
            drive(1'b1, (j == 0 || j == 3), j + 1, 0, 0, 0);
        end
        drive(1'b0, 1'b0, 0, 0, 0, 0);
        drive(1'b0, 1'b0, 0, 0, 0, 0);
        chk("realign_len", lg0.size(), 8);
        if (lg0.size() == 8) begin
            for (int j = 0; j < 8; j++) begin
                chk($sformatf("realign_r[%0d]", j), lg0[j].r, fr_exp[j]);
                chk($sformatf("realign_sync[%0d]", j), lg0[j].sy, (j == 7) ? 1 : 0);
            end
        end

        for (int n = 0; n < 1200; n++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                  int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048,
                  int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
        end
        drive(1'b0, 1'b0, 0, 0, 0, 0);
        drive(1'b0, 1'b0, 0, 0, 0, 0);
        chk("sb0_drained", sb0.size(), 0);
        chk("sb1_drained", sb1.size(), 0);
        chk("sb2_drained", sb2.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
